// File: rtl/btn_cond_pkg.sv
// Shared definitions for the push-button conditioner: channel indices and
// the ADJUST auto-repeat state encoding.
package btn_cond_pkg;

  localparam int unsigned CH_MODE   = 0;
  localparam int unsigned CH_SELECT = 1;
  localparam int unsigned CH_ADJUST = 2;
  localparam int unsigned NUM_CH    = 3;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DELAY  = 2'd1,
    ST_REPEAT = 2'd2
  } rep_state_e;

endpackage

// File: rtl/btn_cond_debounce.sv
// One button channel: two-flop synchroniser, debounce counter and the
// debounced level, plus a combinational released->pressed edge flag.
module btn_debounce #(
  parameter int unsigned DEB_CNT = 500000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_n,
  output logic pressed,
  output logic rise
);

  localparam int unsigned      CW       = $clog2(DEB_CNT);
  localparam logic [CW-1:0]    CNT_LAST = CW'(DEB_CNT - 1);

  logic          sync1_q, sync1_d;
  logic          sync2_q, sync2_d;
  logic          stable_q, stable_d;
  logic          prev_q, prev_d;
  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    sync1_d  = btn_n;
    sync2_d  = sync1_q;
    stable_d = stable_q;
    cnt_d    = cnt_q;
    prev_d   = stable_q;
    // stable_q holds the pressed sense, sync2_q the raw active-low sense
    if (~sync2_q == stable_q) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_LAST) begin
      stable_d = ~sync2_q;
      cnt_d    = '0;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync1_q  <= 1'b1;
      sync2_q  <= 1'b1;
      stable_q <= 1'b0;
      prev_q   <= 1'b0;
      cnt_q    <= '0;
    end else begin
      sync1_q  <= sync1_d;
      sync2_q  <= sync2_d;
      stable_q <= stable_d;
      prev_q   <= prev_d;
      cnt_q    <= cnt_d;
    end
  end

  assign pressed = stable_q;
  assign rise    = stable_q & ~prev_q;

endmodule

// File: rtl/btn_cond.sv
// Button conditioner: debounces MODE/SELECT/ADJUST and emits registered
// single-cycle pulses; ADJUST auto-repeats while held.
module btn_cond
  import btn_cond_pkg::*;
#(
  parameter int unsigned DEB_CNT    = 500000,
  parameter int unsigned REP_DELAY  = 25000000,
  parameter int unsigned REP_PERIOD = 5000000
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic [2:0] BTN_N,
  output logic       MODE,
  output logic       SELECT,
  output logic       ADJUST,
  output logic [2:0] PRESSED
);

  localparam int unsigned   DW = $clog2(REP_DELAY);
  localparam int unsigned   PW = $clog2(REP_PERIOD);
  localparam int unsigned   RW = (DW > PW) ? DW : PW;
  localparam logic [RW-1:0] DELAY_LAST  = RW'(REP_DELAY - 1);
  localparam logic [RW-1:0] PERIOD_LAST = RW'(REP_PERIOD - 1);

  logic [NUM_CH-1:0] pressed;
  logic [NUM_CH-1:0] rise;

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    btn_debounce #(.DEB_CNT(DEB_CNT)) u_deb (
      .clk     (CLK),
      .rst_n   (RST),
      .btn_n   (BTN_N[g]),
      .pressed (pressed[g]),
      .rise    (rise[g])
    );
  end

  rep_state_e    state_q, state_d;
  logic [RW-1:0] rcnt_q, rcnt_d;
  logic          mode_q, mode_d;
  logic          select_q, select_d;
  logic          adjust_q, adjust_d;

  always_comb begin
    state_d  = state_q;
    rcnt_d   = rcnt_q;
    adjust_d = 1'b0;
    mode_d   = rise[CH_MODE];
    select_d = rise[CH_SELECT];
    // a debounced release wins over any repeat pulse due in the same cycle
    if (!pressed[CH_ADJUST]) begin
      state_d = ST_IDLE;
      rcnt_d  = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (rise[CH_ADJUST]) begin
            adjust_d = 1'b1;
            state_d  = ST_DELAY;
            rcnt_d   = '0;
          end
        end
        ST_DELAY: begin
          if (rcnt_q == DELAY_LAST) begin
            adjust_d = 1'b1;
            state_d  = ST_REPEAT;
            rcnt_d   = '0;
          end else begin
            rcnt_d = rcnt_q + 1'b1;
          end
        end
        ST_REPEAT: begin
          if (rcnt_q == PERIOD_LAST) begin
            adjust_d = 1'b1;
            rcnt_d   = '0;
          end else begin
            rcnt_d = rcnt_q + 1'b1;
          end
        end
        default: begin
          state_d = ST_IDLE;
          rcnt_d  = '0;
        end
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (!RST) begin
      state_q  <= ST_IDLE;
      rcnt_q   <= '0;
      mode_q   <= 1'b0;
      select_q <= 1'b0;
      adjust_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      rcnt_q   <= rcnt_d;
      mode_q   <= mode_d;
      select_q <= select_d;
      adjust_q <= adjust_d;
    end
  end

  assign MODE    = mode_q;
  assign SELECT  = select_q;
  assign ADJUST  = adjust_q;
  assign PRESSED = pressed;

endmodule

// File: tb/tb_btn_cond.sv
// Self-checking bench for btn_cond with small timing parameters; a
// sample-history reference model predicts levels and pulses every cycle.
module tb_btn_cond;

  localparam int unsigned DEB = 4;
  localparam int unsigned RD  = 10;
  localparam int unsigned RP  = 3;

  logic       clk   = 1'b0;
  logic       rst_n = 1'b0;
  logic [2:0] btn_n = 3'b111;
  logic       mode, sel, adj;
  logic [2:0] pressed;

  btn_cond #(.DEB_CNT(DEB), .REP_DELAY(RD), .REP_PERIOD(RP)) dut (
    .CLK     (clk),
    .RST     (rst_n),
    .BTN_N   (btn_n),
    .MODE    (mode),
    .SELECT  (sel),
    .ADJUST  (adj),
    .PRESSED (pressed)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference model: raw sample history per channel; a level is accepted
  // once the last DEB synchronised samples all disagree with it.
  logic       hist [3][DEB+2];
  logic       m_stable [3];
  logic       m_rose [3];
  logic [2:0] e_pressed = 3'b000;
  logic       e_mode = 1'b0, e_sel = 1'b0, e_adj = 1'b0;
  logic       adj_active = 1'b0;
  int         adj_wait = 0;

  always @(posedge clk) begin : model
    logic held_before;
    logic all_diff;
    if (!rst_n) begin
      for (int c = 0; c < 3; c++) begin
        for (int k = 0; k < DEB + 2; k++) hist[c][k] = 1'b1;
        m_stable[c] = 1'b0;
        m_rose[c]   = 1'b0;
      end
      e_pressed  = 3'b000;
      e_mode     = 1'b0;
      e_sel      = 1'b0;
      e_adj      = 1'b0;
      adj_active = 1'b0;
      adj_wait   = 0;
    end else begin
      held_before = m_stable[2];
      e_mode = m_rose[0];
      e_sel  = m_rose[1];
      e_adj  = 1'b0;
      if (!held_before) begin
        adj_active = 1'b0;
      end else if (m_rose[2]) begin
        e_adj      = 1'b1;
        adj_active = 1'b1;
        adj_wait   = RD;
      end else if (adj_active) begin
        adj_wait = adj_wait - 1;
        if (adj_wait == 0) begin
          e_adj    = 1'b1;
          adj_wait = RP;
        end
      end
      for (int c = 0; c < 3; c++) begin
        for (int k = DEB + 1; k > 0; k--) hist[c][k] = hist[c][k-1];
        hist[c][0] = btn_n[c];
        all_diff = 1'b1;
        for (int k = 2; k < DEB + 2; k++)
          if ((~hist[c][k]) == m_stable[c]) all_diff = 1'b0;
        m_rose[c] = all_diff & ~m_stable[c];
        if (all_diff) m_stable[c] = ~m_stable[c];
        e_pressed[c] = m_stable[c];
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    btn_n = 3'b111;
    for (int i = 0; i < 3; i++) begin
      tick();
      total++;
      if ({pressed, mode, sel, adj} !== 6'b000000) begin
        bad++;
        $display("FAIL reset_hold cyc=%0d: got %b want %b", i, {pressed, mode, sel, adj}, 6'b000000);
      end
    end
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tick();
      total++;
      if ({pressed, mode, sel, adj} !== 6'b000000) begin
        bad++;
        $display("FAIL reset_idle cyc=%0d: got %b want %b", i, {pressed, mode, sel, adj}, 6'b000000);
      end
    end
  endtask

  task automatic test_clean_mode();
    logic [5:0] exp;
    btn_n[0] = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      exp = '0;
      exp[3] = (i >= DEB + 1);
      exp[2] = (i == DEB + 2);
      total++;
      if ({pressed, mode, sel, adj} !== exp) begin
        bad++;
        $display("FAIL clean_mode edge=%0d: got %b want %b", i, {pressed, mode, sel, adj}, exp);
      end
    end
    btn_n[0] = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      exp = '0;
      exp[3] = (i < DEB + 1);
      total++;
      if ({pressed, mode, sel, adj} !== exp) begin
        bad++;
        $display("FAIL mode_release edge=%0d: got %b want %b", i, {pressed, mode, sel, adj}, exp);
      end
    end
  endtask

  task automatic test_bounce();
    for (int i = 0; i < 20; i++) begin
      if (i % 2 == 0) btn_n[1] = ~btn_n[1];
      tick();
      total++;
      if ({pressed[1], sel} !== 2'b00) begin
        bad++;
        $display("FAIL bounce_fixed cyc=%0d: got %b want 00", i, {pressed[1], sel});
      end
    end
    for (int r = 0; r < 30; r++) begin
      int unsigned len;
      btn_n[1] = ~btn_n[1];
      len = $urandom_range(1, DEB - 1);
      for (int unsigned j = 0; j < len; j++) begin
        tick();
        total++;
        if ({pressed[1], sel} !== 2'b00 || {pressed, mode, sel, adj} !== {e_pressed, e_mode, e_sel, e_adj}) begin
          bad++;
          $display("FAIL bounce_rand run=%0d: got %b want %b", r, {pressed, mode, sel, adj}, {e_pressed, e_mode, e_sel, e_adj});
        end
      end
    end
    btn_n[1] = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      total++;
      if ({pressed[1], sel} !== 2'b00) begin
        bad++;
        $display("FAIL bounce_settle cyc=%0d: got %b want 00", i, {pressed[1], sel});
      end
    end
  endtask

  task automatic test_adjust_repeat();
    int hold;
    logic exp_adj, exp_pr;
    hold = 30 + int'($urandom_range(0, 12));
    btn_n[2] = 1'b0;
    for (int i = 0; i < DEB + 3; i++) begin
      tick();
      total++;
      if (adj !== ((i == DEB + 2) ? 1'b1 : 1'b0)) begin
        bad++;
        $display("FAIL adj_first edge=%0d: got %b want %b", i, adj, (i == DEB + 2));
      end
    end
    // r counts cycles relative to the first ADJUST pulse (r = 0)
    for (int r = 1; r <= hold + 20; r++) begin
      if (r == hold + 1) btn_n[2] = 1'b1;
      tick();
      exp_adj = (r >= RD) && ((r - RD) % RP == 0) && (r <= hold + DEB + 2);
      exp_pr  = (r < hold + DEB + 2);
      total++;
      if ({pressed[2], adj} !== {exp_pr, exp_adj} || {pressed, mode, sel, adj} !== {e_pressed, e_mode, e_sel, e_adj}) begin
        bad++;
        $display("FAIL adj_repeat rel=%0d: got %b/%b want %b/%b", r, pressed[2], adj, exp_pr, exp_adj);
      end
    end
  endtask

  task automatic test_simultaneous();
    logic [5:0] exp;
    btn_n = 3'b100;
    for (int i = 0; i < 12; i++) begin
      tick();
      exp = '0;
      exp[4] = (i >= DEB + 1);
      exp[3] = (i >= DEB + 1);
      exp[2] = (i == DEB + 2);
      exp[1] = (i == DEB + 2);
      total++;
      if ({pressed, mode, sel, adj} !== exp) begin
        bad++;
        $display("FAIL simultaneous edge=%0d: got %b want %b", i, {pressed, mode, sel, adj}, exp);
      end
    end
    btn_n = 3'b111;
    for (int i = 0; i < 10; i++) tick();
  endtask

  task automatic test_reset_mid();
    logic [5:0] exp;
    btn_n[2] = 1'b0;
    for (int i = 0; i < 25; i++) begin
      tick();
      total++;
      if ({pressed, mode, sel, adj} !== {e_pressed, e_mode, e_sel, e_adj}) begin
        bad++;
        $display("FAIL mid_pre cyc=%0d: got %b want %b", i, {pressed, mode, sel, adj}, {e_pressed, e_mode, e_sel, e_adj});
      end
    end
    rst_n = 1'b0;
    tick();
    total++;
    if ({pressed, mode, sel, adj} !== 6'b000000) begin
      bad++;
      $display("FAIL mid_reset: got %b want %b", {pressed, mode, sel, adj}, 6'b000000);
    end
    rst_n = 1'b1;
    for (int i = 0; i < 15; i++) begin
      tick();
      exp = '0;
      exp[5] = (i >= DEB + 1);
      exp[0] = (i == DEB + 2);
      total++;
      if ({pressed, mode, sel, adj} !== exp) begin
        bad++;
        $display("FAIL mid_after edge=%0d: got %b want %b", i, {pressed, mode, sel, adj}, exp);
      end
    end
    btn_n = 3'b111;
    for (int i = 0; i < 10; i++) tick();
  endtask

  task automatic test_random();
    for (int s = 0; s < 80; s++) begin
      int unsigned len;
      btn_n = 3'($urandom_range(0, 7));
      rst_n = ($urandom_range(0, 19) == 0) ? 1'b0 : 1'b1;
      len = $urandom_range(1, 14);
      for (int unsigned j = 0; j < len; j++) begin
        tick();
        rst_n = 1'b1;
        total++;
        if ({pressed, mode, sel, adj} !== {e_pressed, e_mode, e_sel, e_adj}) begin
          bad++;
          $display("FAIL random seg=%0d: got %b want %b", s, {pressed, mode, sel, adj}, {e_pressed, e_mode, e_sel, e_adj});
        end
      end
    end
    btn_n = 3'b111;
    for (int i = 0; i < 25; i++) begin
      tick();
      total++;
      if ({pressed, mode, sel, adj} !== {e_pressed, e_mode, e_sel, e_adj}) begin
        bad++;
        $display("FAIL random_tail cyc=%0d: got %b want %b", i, {pressed, mode, sel, adj}, {e_pressed, e_mode, e_sel, e_adj});
      end
    end
  endtask

  initial begin
    test_reset();
    test_clean_mode();
    test_bounce();
    test_adjust_repeat();
    test_simultaneous();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
